// File: rtl/random_range_sampler.sv
// Bounded uniform sampler on top of the 30-bit LFSR: mask-and-reject into [0, limit), buffered in a small FIFO.
// Define RANGE_SAMPLER_STATS_EN to build the saturating reject counter; otherwise reject_cnt is tied to 0.
module random_range_sampler #(
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [OUT_W-1:0] limit,
   input  logic [29:0]      rnd_in,
   output logic             rnd_ena,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      reject_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SAMPLE} state_t;

   state_t           state;
   logic [OUT_W-1:0] lim_q, mask_q, mask_c, cand, hold_q;
   logic [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, fill;
   logic             full, empty, accept, push, pop, flush;
   logic             unused_rnd;

   assign unused_rnd = ^rnd_in;

   // Smear limit-1 rightwards: smallest 2^k-1 covering it; limit=0 wraps to all ones.
   always_comb begin
      mask_c = limit - OUT_W'(1);
      for (int i = 1; i < OUT_W; i++)
         mask_c = mask_c | (mask_c >> i);
   end

   assign fill      = wr_ptr - rd_ptr;
   assign full      = (fill == (AW+1)'(FIFO_DEPTH));
   assign empty     = (fill == '0);
   assign cand      = rnd_in[OUT_W-1:0] & mask_q;
   assign accept    = (lim_q == '0) || (cand < lim_q);
   assign rnd_ena   = (state == SAMPLE) && !full;
   assign push      = rnd_ena && accept;
   assign pop       = !empty && out_ready;
   assign flush     = (state == IDLE) || !enable;
   assign out_valid = !empty;
   // Head is shown while non-empty; otherwise the last shown value is held.
   assign out_data  = empty ? hold_q : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         lim_q  <= '0;
         mask_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         hold_q <= '0;
      end else begin
         hold_q <= out_data;
         case (state)
            IDLE:    if (enable) state <= LOAD;
            LOAD: begin
               lim_q  <= limit;
               mask_q <= mask_c;
               state  <= enable ? SAMPLE : IDLE;
            end
            SAMPLE:  if (!enable) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= cand;
   end

`ifdef RANGE_SAMPLER_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         reject_cnt <= '0;
      else if (state == IDLE && enable)
         reject_cnt <= '0;
      else if (rnd_ena && !accept && reject_cnt != 16'hFFFF)
         reject_cnt <= reject_cnt + 16'd1;
   end
`else
   assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Scoreboard bench for random_range_sampler: expected values queued as candidates are consumed, compared on pop.
module tb_random_range_sampler;
   localparam int OUT_W = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, enable, out_ready, rnd_ena, out_valid;
   logic [15:0] limit, out_data, reject_cnt;
   logic [29:0] rnd_in;

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] lim_m, mask_m, cand_m;
   int          rej_m = 0;
   bit          mon_en = 1'b0;

   random_range_sampler #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .limit(limit), .rnd_in(rnd_in),
      .rnd_ena(rnd_ena), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int exp_rej(input int n);
`ifdef RANGE_SAMPLER_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise enable with the bench's own idea of limit and mask; returns in the first SAMPLE cycle.
   task automatic start(input logic [15:0] lim, input logic [15:0] msk);
      limit  = lim;
      lim_m  = lim;
      mask_m = msk;
      rej_m  = 0;
      enable = 1'b1;
      tick();
      check("load_ena", rnd_ena, 1'b0);
      tick();
   endtask

   task automatic leave();
      enable = 1'b0;
      tick();
      check("idle_valid", out_valid, 1'b0);
      check("idle_ena", rnd_ena, 1'b0);
      exp_q.delete();
   endtask

   // Pop first (head compare), then queue whatever the DUT consumes this cycle.
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else check("sb_data", out_data, exp_q.pop_front());
         end
         if (rnd_ena) begin
            cand_m = rnd_in[15:0] & mask_m;
            if (lim_m == 16'd0 || cand_m < lim_m) exp_q.push_back(cand_m);
            else if (rej_m < 65535) rej_m++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; enable = 1'b0; out_ready = 1'b0; limit = '0; rnd_in = '0;
      lim_m = '0; mask_m = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ena", rnd_ena, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 16'h0);
      check("rst_rej", reject_cnt, 16'h0);
      rst = 1'b1;
      repeat (10) begin
         tick();
         check("idle_ena", rnd_ena, 1'b0);
         check("idle_valid", out_valid, 1'b0);
         check("idle_rej", reject_cnt, 16'h0);
      end
      mon_en = 1'b1;

      // rejection: limit 10, mask 0xF
      out_ready = 1'b1;
      start(16'd10, 16'h000F);
      check("rej_ena", rnd_ena, 1'b1);
      rnd_in = 30'h0000_000C;
      tick();
      check("rej_cnt1", reject_cnt, exp_rej(1));
      check("rej_novalid", out_valid, 1'b0);
      rnd_in = 30'h0000_0007;
      tick();
      check("rej_valid", out_valid, 1'b1);
      check("rej_data", out_data, 16'h0007);
      rnd_in = 30'h0000_000C;
      tick();
      leave();
      check("rej_hold", reject_cnt, exp_rej(rej_m));

      // full range: limit 0
      start(16'd0, 16'hFFFF);
      check("full_rej0", reject_cnt, 16'h0);
      rnd_in = 30'h0000_0400;
      tick();
      check("full_valid", out_valid, 1'b1);
      check("full_d0", out_data, 16'h0400);
      rnd_in = 30'h0000_0800;
      tick();
      check("full_d1", out_data, 16'h0800);
      rnd_in = $urandom;
      tick();
      leave();
      check("full_rej", reject_cnt, 16'h0);

      // backpressure
      out_ready = 1'b0;
      start(16'd0, 16'hFFFF);
      repeat (DEPTH) begin
         rnd_in = $urandom;
         tick();
      end
      check("bp_full", rnd_ena, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      repeat (3) begin
         rnd_in = $urandom;
         tick();
         check("bp_stay", rnd_ena, 1'b0);
      end
      out_ready = 1'b1;
      check("bp_nobypass", rnd_ena, 1'b0);
      tick();
      out_ready = 1'b0;
      check("bp_reena", rnd_ena, 1'b1);
      rnd_in = $urandom;
      tick();
      check("bp_refull", rnd_ena, 1'b0);
      out_ready = 1'b1;
      repeat (8) begin
         rnd_in = $urandom;
         tick();
      end
      leave();

      // limit latching: change to 3 mid-run is ignored until re-LOAD
      start(16'd10, 16'h000F);
      limit = 16'd3;
      repeat (40) begin
         rnd_in = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("latch_rej10", reject_cnt, exp_rej(rej_m));
      enable = 1'b0;
      tick();
      check("latch_flush", out_valid, 1'b0);
      exp_q.delete();
      start(16'd3, 16'h0003);
      repeat (40) begin
         rnd_in = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("latch_rej3", reject_cnt, exp_rej(rej_m));
      out_ready = 1'b1;
      repeat (4) begin
         rnd_in = $urandom;
         tick();
      end
      leave();

      // asynchronous reset with two entries queued
      out_ready = 1'b0;
      start(16'd0, 16'hFFFF);
      rnd_in = $urandom;
      tick();
      rnd_in = $urandom;
      tick();
      check("mid_valid", out_valid, 1'b1);
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mid_valid0", out_valid, 1'b0);
      check("mid_ena0", rnd_ena, 1'b0);
      check("mid_data0", out_data, 16'h0);
      check("mid_rej0", reject_cnt, 16'h0);
      exp_q.delete();
      enable = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("post_valid", out_valid, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
